wb_regfile: RTL and testbench

Writeback-end register file for the five-stage MIPS core: consumes the WB stage register outputs, forms the final writeback value (ALU result, extracted load data, or link address), and commits it to a 32×32 general-purpose register file. The block also serves the ID stage's two combinational read ports with same-cycle write bypass and maintains a retired-instruction counter. It sits after the WB stage register and feeds ID operand fetch and EX forwarding.

---
 rtl/wb_regfile_pkg.sv | 25 ++
 rtl/wb_regfile_load_extract.sv | 29 ++
 rtl/wb_regfile.sv | 63 ++++++
 tb/tb_wb_regfile.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: ISA constants shared by the writeback/register-file slice.
// Holds the word/register-index widths, the opcodes and funct codes that
// steer writeback selection and load extraction, and the $sp register index.
package wb_regfile_pkg;

    localparam int WORD = 32;
    localparam int REG  = 5;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam int SP = 29;

    // JAL and JALR both write the return address rather than the ALU result.
    function automatic logic is_link(input logic [WORD-1:0] ins);
        return (ins[31:26] == OP_JAL) || (ins[31:26] == OP_SPECIAL && ins[5:0] == FN_JALR);
    endfunction

endpackage

// File: rtl/wb_regfile_load_extract.sv
// wb_load_extract: big-endian sub-word load extraction (purely combinational).
// Ports: i_word  aligned memory word
//        i_addr  low address bits (byte index; bit 0 ignored for halfwords)
//        i_op    load opcode; anything unrecognised behaves as LW
//        o_data  sign/zero-extended load result
module wb_load_extract
    import wb_regfile_pkg::*;
(
    input  logic [WORD-1:0] i_word,
    input  logic [1:0]      i_addr,
    input  logic [5:0]      i_op,
    output logic [WORD-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte 0 is the most significant byte.
    assign w_byte = (i_addr == 2'd0) ? i_word[31:24] :
                    (i_addr == 2'd1) ? i_word[23:16] :
                    (i_addr == 2'd2) ? i_word[15:8]  : i_word[7:0];
    assign w_half = i_addr[1] ? i_word[15:0] : i_word[31:16];

    assign o_data = (i_op == OP_LB)  ? {{24{w_byte[7]}}, w_byte} :
                    (i_op == OP_LBU) ? {24'b0, w_byte}           :
                    (i_op == OP_LH)  ? {{16{w_half[15]}}, w_half} :
                    (i_op == OP_LHU) ? {16'b0, w_half}           : i_word;

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, 32x32 GPR file with write bypass, retire counter.
// Ports: clk/rst_n      clock, async active-low reset
//        wb*            WB stage register outputs (link PC, instruction,
//                       ALU result/load address, memory word, dest reg, load flag)
//        rsAddr/rtAddr  ID read addresses; rsData/rtData combinational read data
//        wbWriteData    final writeback value (also used for EX forwarding)
//        retired        count of committed non-bubble instructions
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_SP = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] wbNewPC,
    input  logic [WORD-1:0] wbInstruction,
    input  logic [WORD-1:0] wbALUOut,
    input  logic [WORD-1:0] wbMemOut,
    input  logic [REG-1:0]  wbWriteReg,
    input  logic            wbMemRead,
    input  logic [REG-1:0]  rsAddr,
    input  logic [REG-1:0]  rtAddr,
    output logic [WORD-1:0] rsData,
    output logic [WORD-1:0] rtData,
    output logic [WORD-1:0] wbWriteData,
    output logic [WORD-1:0] retired
);

    // r0 is hard-wired to zero, so it has no storage.
    logic [WORD-1:0] r_regs [1:31];
    logic [WORD-1:0] r_retired;
    logic [WORD-1:0] w_load;

    wb_load_extract u_extract (
        .i_word (wbMemOut),
        .i_addr (wbALUOut[1:0]),
        .i_op   (wbInstruction[31:26]),
        .o_data (w_load)
    );

    assign wbWriteData = wbMemRead ? w_load :
                         is_link(wbInstruction) ? wbNewPC : wbALUOut;

    // A register being written this cycle is seen through the bypass.
    assign rsData = (rsAddr == '0) ? '0 : (rsAddr == wbWriteReg) ? wbWriteData : r_regs[rsAddr];
    assign rtData = (rtAddr == '0) ? '0 : (rtAddr == wbWriteReg) ? wbWriteData : r_regs[rtAddr];

    assign retired = r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++)
                r_regs[i] <= (i == SP) ? RESET_SP : '0;
            r_retired <= '0;
        end else begin
            if (wbWriteReg != '0)
                r_regs[wbWriteReg] <= wbWriteData;
            if (wbInstruction != '0)
                r_retired <= r_retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized self-checking bench for wb_regfile against a
// behavioural register-file model; inputs change on negedge like the WB stage.
module tb_wb_regfile;

    localparam logic [31:0] SP_INIT = 32'h7FFF_EFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbNewPC = '0, wbInstruction = '0, wbALUOut = '0, wbMemOut = '0;
    logic [4:0]  wbWriteReg = '0, rsAddr = '0, rtAddr = '0;
    logic        wbMemRead = 1'b0;
    logic [31:0] rsData, rtData, wbWriteData, retired;

    logic [31:0] m_regs [32];
    logic [31:0] m_ret;
    int          n_pass = 0;
    int          n_total = 0;

    wb_regfile #(.RESET_SP(SP_INIT)) dut (
        .clk(clk), .rst_n(rst_n), .wbNewPC(wbNewPC), .wbInstruction(wbInstruction),
        .wbALUOut(wbALUOut), .wbMemOut(wbMemOut), .wbWriteReg(wbWriteReg),
        .wbMemRead(wbMemRead), .rsAddr(rsAddr), .rtAddr(rtAddr), .rsData(rsData),
        .rtData(rtData), .wbWriteData(wbWriteData), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_wd();
        logic [5:0]  op;
        logic [7:0]  b;
        logic [15:0] h;
        int          sh;
        op = wbInstruction[31:26];
        sh = 8 * (3 - int'(wbALUOut[1:0]));
        b  = 8'(wbMemOut >> sh);
        h  = 16'(wbMemOut >> (wbALUOut[1] ? 0 : 16));
        if (wbMemRead) begin
            case (op)
                6'h20:   return {{24{b[7]}}, b};
                6'h24:   return {24'h0, b};
                6'h21:   return {{16{h[15]}}, h};
                6'h25:   return {16'h0, h};
                default: return wbMemOut;
            endcase
        end
        if (op == 6'h03 || (op == 6'h00 && wbInstruction[5:0] == 6'h09))
            return wbNewPC;
        return wbALUOut;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (a == wbWriteReg) return exp_wd();
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_regs[29] = SP_INIT;
        m_ret = 32'h0;
    endtask

    task automatic put(input logic [31:0] ins, alu, mem, pc, input logic [4:0] wr, input logic rd);
        @(negedge clk);
        wbInstruction = ins; wbALUOut = alu; wbMemOut = mem; wbNewPC = pc;
        wbWriteReg = wr; wbMemRead = rd;
        #1;
    endtask

    task automatic bubble();
        put(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        if (wbWriteReg != 0) m_regs[wbWriteReg] = exp_wd();
        if (wbInstruction != 0) m_ret = m_ret + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsAddr = 5'd29; rtAddr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_total++; if (rsData !== 32'h7FFF_EFFC) $display("FAIL reset_sp got=%h exp=%h", rsData, 32'h7FFF_EFFC); else n_pass++;
        n_total++; if (rtData !== 32'h0) $display("FAIL reset_r5 got=%h exp=0", rtData); else n_pass++;
        n_total++; if (retired !== 32'h0) $display("FAIL reset_retired got=%h exp=0", retired); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_alu_bypass();
        rsAddr = 5'd8;
        put(32'h0109_4020, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 1'b0);
        n_total++; if (rsData !== 32'h1234_5678) $display("FAIL bypass_rs got=%h exp=12345678", rsData); else n_pass++;
        step();
        bubble();
        n_total++; if (rsData !== 32'h1234_5678) $display("FAIL array_r8 got=%h exp=12345678", rsData); else n_pass++;
        n_total++; if (retired !== 32'd1) $display("FAIL retired_one got=%h exp=1", retired); else n_pass++;
    endtask

    task automatic test_load();
        logic [5:0]  ops [4] = '{6'h20, 6'h24, 6'h21, 6'h25};
        logic [1:0]  adr [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [31:0] res [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF};
        for (int k = 0; k < 4; k++) begin
            rtAddr = 5'(10 + k);
            put({ops[k], 26'h0}, {30'h0000_0100, adr[k]}, 32'h80FF_7F01, 32'h0, 5'(10 + k), 1'b1);
            n_total++; if (wbWriteData !== res[k]) $display("FAIL load_%0d got=%h exp=%h", k, wbWriteData, res[k]); else n_pass++;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            rtAddr = 5'(10 + k);
            bubble();
            n_total++; if (rtData !== res[k]) $display("FAIL load_reg_%0d got=%h exp=%h", k, rtData, res[k]); else n_pass++;
        end
    endtask

    task automatic test_link_r0();
        logic [31:0] r;
        rsAddr = 5'd31;
        put({6'h03, 26'h10}, 32'hAAAA_5555, 32'h0, 32'h0040_0010, 5'd31, 1'b0);
        step();
        bubble();
        n_total++; if (rsData !== 32'h0040_0010) $display("FAIL jal_r31 got=%h exp=00400010", rsData); else n_pass++;
        rtAddr = 5'd30;
        put({6'h00, 5'd4, 15'h0, 6'h09}, 32'h1111_1111, 32'h0, 32'h0040_0100, 5'd30, 1'b0);
        n_total++; if (rtData !== 32'h0040_0100) $display("FAIL jalr_bypass got=%h exp=00400100", rtData); else n_pass++;
        step();
        rsAddr = 5'd0;
        r = m_ret;
        put(32'h0109_4020, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b0);
        n_total++; if (rsData !== 32'h0) $display("FAIL r0_bypass got=%h exp=0", rsData); else n_pass++;
        step();
        n_total++; if (rsData !== 32'h0) $display("FAIL r0_read got=%h exp=0", rsData); else n_pass++;
        n_total++; if (retired !== r + 1) $display("FAIL r0_retired got=%h exp=%h", retired, r + 1); else n_pass++;
    endtask

    task automatic test_bubble_wrap();
        bubble();
        step();
        n_total++; if (retired !== m_ret) $display("FAIL bubble_retired got=%h exp=%h", retired, m_ret); else n_pass++;
        @(negedge clk);
        force dut.r_retired = 32'hFFFF_FFFF;
        #1 release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        put(32'h0109_4020, 32'h5, 32'h0, 32'h0, 5'd3, 1'b0);
        step();
        n_total++; if (retired !== 32'h0) $display("FAIL wrap_retired got=%h exp=0", retired); else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] lops [6] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
        logic [31:0] ins;
        logic        rd;
        logic [4:0]  wr;
        int          kind, sel;
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 5));
            rd = 1'b0;
            case (kind)
                0: ins = 32'h0;
                1: ins = {6'h08, 26'($urandom)};
                2: begin ins = {lops[$urandom_range(0, 5)], 26'($urandom)}; rd = 1'b1; end
                3: ins = {6'h03, 26'($urandom)};
                4: ins = {6'h00, 20'($urandom), 6'h09};
                default: begin ins = {6'h03, 26'($urandom)}; rd = 1'b1; end
            endcase
            sel = int'($urandom_range(0, 9));
            wr = (sel == 8) ? 5'd29 : (sel == 9) ? 5'd31 : 5'(sel);
            rsAddr = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            rtAddr = 5'($urandom_range(0, 9));
            put(ins, $urandom, $urandom, $urandom, wr, rd);
            n_total++; if (wbWriteData !== exp_wd()) $display("FAIL rnd_wd_%0d got=%h exp=%h", n, wbWriteData, exp_wd()); else n_pass++;
            n_total++; if (rsData !== exp_rd(rsAddr)) $display("FAIL rnd_rs_%0d got=%h exp=%h", n, rsData, exp_rd(rsAddr)); else n_pass++;
            n_total++; if (rtData !== exp_rd(rtAddr)) $display("FAIL rnd_rt_%0d got=%h exp=%h", n, rtData, exp_rd(rtAddr)); else n_pass++;
            step();
            n_total++; if (retired !== m_ret) $display("FAIL rnd_ret_%0d got=%h exp=%h", n, retired, m_ret); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        rsAddr = 5'd9; rtAddr = 5'd29;
        put(32'h0109_4020, 32'hCAFE_0009, 32'h0, 32'h0, 5'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_total++; if (retired !== 32'h0) $display("FAIL async_retired got=%h exp=0", retired); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (retired !== 32'h0) $display("FAIL held_retired got=%h exp=0", retired); else n_pass++;
        bubble();
        n_total++; if (rsData !== 32'h0) $display("FAIL async_r9 got=%h exp=0", rsData); else n_pass++;
        n_total++; if (rtData !== SP_INIT) $display("FAIL async_sp got=%h exp=%h", rtData, SP_INIT); else n_pass++;
        rst_n = 1'b1;
        put(32'h0109_4020, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd9, 1'b0);
        step();
        bubble();
        n_total++; if (rsData !== 32'h0BAD_F00D) $display("FAIL post_reset_r9 got=%h exp=0badf00d", rsData); else n_pass++;
        n_total++; if (retired !== 32'd1) $display("FAIL post_reset_ret got=%h exp=1", retired); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_load();
        test_link_r0();
        test_bubble_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
